// File: rtl/pilot_level_ctrl.sv
// pilot_level_ctrl
//   Closed-loop pilot-level controller for the stereo MPX path (mclk domain).
//   Repeatedly runs measurement windows on the sigstat block: clear, enable,
//   wait for the sample count, freeze. It then reads min/max, forms the
//   peak-to-peak value and steps pilot_gain toward target_pp with saturation.
//   Lock status and sticky measurement timeouts are reported for the APB
//   register block.
//
// Build option
//   PILOT_LVL_CTRL_PROP_STEP_EN : when defined, the UPDATE step is proportional
//   to the error, (max(1, (|err| - deadband) >> 2) << 4), capped at
//   16*GAIN_STEP. When undefined, the step is fixed at GAIN_STEP.
//
// Ports
//   mclk, mreset_n   clock, synchronous active-low reset
//   enable           1 = run control loop, 0 = stop and hold gain
//   target_pp        target peak-to-peak (unsigned, 9 bit)
//   deadband         allowed |pp - target_pp| without a gain change
//   window           samples per measurement window (0 treated as 1)
//   gain_load        1-cycle pulse: load gain_load_val into pilot_gain
//   gain_load_val    gain preset value
//   stat_cfg         to sigstat: bit0 = reset, bit1 = enable
//   stat_limit       to sigstat: window length latched at window start
//   stat_min/max     from sigstat, signed 8 bit
//   stat_count       from sigstat, valid samples in current window
//   pilot_gain       to pilot gain stage (registered)
//   busy             1 while the FSM is not IDLE
//   locked           loop has held inside the deadband LOCK_COUNT times
//   timeout_err      sticky RUN timeout, cleared by a rising edge of enable
module pilot_level_ctrl #(
    parameter int unsigned             GAIN_WIDTH = 16,
    parameter logic [GAIN_WIDTH-1:0]   GAIN_INIT  = 16'h0100,
    parameter int unsigned             GAIN_STEP  = 16,
    parameter int unsigned             LOCK_COUNT = 4,
    parameter int unsigned             TIMEOUT    = 2**24
) (
    input  logic                  mclk,
    input  logic                  mreset_n,
    input  logic                  enable,
    input  logic [8:0]            target_pp,
    input  logic [7:0]            deadband,
    input  logic [31:0]           window,
    input  logic                  gain_load,
    input  logic [GAIN_WIDTH-1:0] gain_load_val,
    output logic [1:0]            stat_cfg,
    output logic [31:0]           stat_limit,
    input  logic [7:0]            stat_min,
    input  logic [7:0]            stat_max,
    input  logic [31:0]           stat_count,
    output logic [GAIN_WIDTH-1:0] pilot_gain,
    output logic                  busy,
    output logic                  locked,
    output logic                  timeout_err
);

    localparam int unsigned WD_W = $clog2(TIMEOUT) + 1;
    localparam int unsigned LC_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned SW   = GAIN_WIDTH + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [LC_W-1:0] LC_MAX  = LC_W'(LOCK_COUNT);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        HOLD,
        EVAL,
        UPDATE
    } state_t;

    state_t                state, state_next;
    logic [WD_W-1:0]       watchdog;
    logic [LC_W-1:0]       lock_cnt;
    logic [LC_W-1:0]       lock_cnt_inc;
    logic                  enable_q;
    logic signed [9:0]     err_q;
    logic signed [9:0]     err_next;
    logic signed [9:0]     db_s;
    logic [8:0]            pp;
    logic [1:0]            cfg_next;
    logic                  run_done;
    logic                  timeout_hit;
    logic                  err_hi;
    logic                  err_lo;
    logic [SW-1:0]         step;
    logic [SW-1:0]         gain_sum;
    logic [SW-1:0]         gain_diff;
    logic [GAIN_WIDTH-1:0] gain_up;
    logic [GAIN_WIDTH-1:0] gain_dn;

    // Next-state logic. enable=0 forces IDLE from every state (UPDATE still
    // applies its gain step in its own block); a gain_load while busy
    // abandons the running window and restarts at CLEAR.
    always_comb begin
        state_next  = state;
        run_done    = (stat_count >= stat_limit);
        timeout_hit = 1'b0;
        unique case (state)
            IDLE:    if (enable) state_next = CLEAR;
            CLEAR:   state_next = RUN;
            RUN: begin
                if (run_done) begin
                    state_next = HOLD;
                end else if (watchdog == WD_LAST) begin
                    state_next  = CLEAR;
                    timeout_hit = enable;
                end
            end
            HOLD:    state_next = EVAL;
            EVAL:    state_next = UPDATE;
            UPDATE:  state_next = enable ? CLEAR : IDLE;
            default: state_next = IDLE;
        endcase
        if (!enable) begin
            state_next = IDLE;
        end else if (gain_load && (state != IDLE)) begin
            state_next = CLEAR;
        end

        // min/max stay frozen from HOLD through UPDATE
        unique case (state_next)
            RUN:                cfg_next = 2'b10;
            HOLD, EVAL, UPDATE: cfg_next = 2'b00;
            default:            cfg_next = 2'b01;
        endcase
    end

    // Error and step computation.
    always_comb begin
        pp       = {stat_max[7], stat_max} - {stat_min[7], stat_min};
        err_next = $signed({1'b0, pp}) - $signed({1'b0, target_pp});
        db_s     = $signed({2'b00, deadband});
        err_hi   = (err_q > db_s);
        err_lo   = (err_q < -db_s);
        lock_cnt_inc = (lock_cnt == LC_MAX) ? lock_cnt : lock_cnt + 1'b1;
    end

`ifdef PILOT_LVL_CTRL_PROP_STEP_EN
    localparam int unsigned STEP_CAP = 16 * GAIN_STEP;
    logic [9:0]  err_mag;
    logic [9:0]  excess;
    logic [11:0] prop_raw;

    // Only used when the error lies outside the deadband, so excess >= 1.
    always_comb begin
        err_mag  = err_q[9] ? $unsigned(-err_q) : $unsigned(err_q);
        excess   = err_mag - {2'b00, deadband};
        prop_raw = {(excess[9:2] == 8'd0) ? 8'd1 : excess[9:2], 4'b0000};
        if (32'(prop_raw) > STEP_CAP) begin
            step = SW'(STEP_CAP);
        end else begin
            step = SW'(prop_raw);
        end
    end
`else
    always_comb begin
        step = SW'(GAIN_STEP);
    end
`endif

    // One extra bit catches carry (up) and borrow (down) for saturation.
    always_comb begin
        gain_sum  = {1'b0, pilot_gain} + step;
        gain_diff = {1'b0, pilot_gain} - step;
        gain_up   = gain_sum[GAIN_WIDTH]  ? '1 : gain_sum[GAIN_WIDTH-1:0];
        gain_dn   = gain_diff[GAIN_WIDTH] ? '0 : gain_diff[GAIN_WIDTH-1:0];
    end

    always_ff @(posedge mclk) begin
        if (!mreset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge mclk) begin
        if (!mreset_n) begin
            stat_cfg    <= 2'b01;
            stat_limit  <= '0;
            pilot_gain  <= GAIN_INIT;
            busy        <= 1'b0;
            locked      <= 1'b0;
            timeout_err <= 1'b0;
            lock_cnt    <= '0;
            watchdog    <= '0;
            enable_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            enable_q <= enable;
            stat_cfg <= cfg_next;
            busy     <= (state_next != IDLE);

            if (state == CLEAR) begin
                stat_limit <= (window == '0) ? 32'd1 : window;
                watchdog   <= '0;
            end else if (state == RUN) begin
                watchdog <= watchdog + 1'b1;
            end

            if (state == EVAL) begin
                err_q <= err_next;
            end

            if (state == UPDATE) begin
                if (err_hi || err_lo) begin
                    pilot_gain <= err_hi ? gain_dn : gain_up;
                    lock_cnt   <= '0;
                    locked     <= 1'b0;
                end else begin
                    lock_cnt <= lock_cnt_inc;
                    if (lock_cnt_inc == LC_MAX) begin
                        locked <= 1'b1;
                    end
                end
            end

            if (timeout_hit) begin
                lock_cnt <= '0;
                locked   <= 1'b0;
            end

            // gain_load overrides any UPDATE in the same cycle
            if (gain_load) begin
                pilot_gain <= gain_load_val;
                lock_cnt   <= '0;
                locked     <= 1'b0;
            end

            // a timeout in the same cycle as the enable edge wins
            if (enable && !enable_q) begin
                timeout_err <= 1'b0;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pilot_level_ctrl.sv
// tb_pilot_level_ctrl
//   Scoreboard bench for pilot_level_ctrl. The stimulus pushes the expected
//   gain/locked result of each measurement window into a queue; a monitor pops
//   and compares whenever the DUT leaves UPDATE (stat_cfg 00 -> non-00).
//   A second instance with a short TIMEOUT exercises the RUN watchdog.
module tb_pilot_level_ctrl;

    logic        mclk = 1'b0;
    logic        mreset_n;
    logic        enable;
    logic [8:0]  target_pp;
    logic [7:0]  deadband;
    logic [31:0] window;
    logic        gain_load;
    logic [15:0] gain_load_val;
    logic [1:0]  stat_cfg;
    logic [31:0] stat_limit;
    logic [7:0]  stat_min;
    logic [7:0]  stat_max;
    logic [31:0] stat_count;
    logic [15:0] pilot_gain;
    logic        busy;
    logic        locked;
    logic        timeout_err;

    logic        to_enable;
    logic [1:0]  to_cfg;
    logic [31:0] to_limit;
    logic [31:0] to_count;
    logic [15:0] to_gain;
    logic        to_busy;
    logic        to_locked;
    logic        to_err;

    int total = 0;
    int bad   = 0;
    int unsigned cyc = 0;
    int unsigned last_done = 0;
    logic [1:0] cfg_prev = 2'b01;

    typedef struct {
        logic [15:0] gain;
        logic        lck;
        bit          per;
    } exp_t;
    exp_t q[$];

    always #5 mclk = ~mclk;

    pilot_level_ctrl #(
        .GAIN_WIDTH(16)
    ) dut (
        .mclk(mclk), .mreset_n(mreset_n), .enable(enable),
        .target_pp(target_pp), .deadband(deadband), .window(window),
        .gain_load(gain_load), .gain_load_val(gain_load_val),
        .stat_cfg(stat_cfg), .stat_limit(stat_limit),
        .stat_min(stat_min), .stat_max(stat_max), .stat_count(stat_count),
        .pilot_gain(pilot_gain), .busy(busy), .locked(locked),
        .timeout_err(timeout_err)
    );

    pilot_level_ctrl #(
        .TIMEOUT(64)
    ) dut_to (
        .mclk(mclk), .mreset_n(mreset_n), .enable(to_enable),
        .target_pp(9'd0), .deadband(8'd0), .window(32'd10),
        .gain_load(1'b0), .gain_load_val(16'h0000),
        .stat_cfg(to_cfg), .stat_limit(to_limit),
        .stat_min(8'd0), .stat_max(8'd0), .stat_count(to_count),
        .pilot_gain(to_gain), .busy(to_busy), .locked(to_locked),
        .timeout_err(to_err)
    );

    // sigstat sample counter model: one sample per cycle while enabled
    assign to_count = 32'd0;
    always @(posedge mclk) begin
        cyc <= cyc + 1;
        if (stat_cfg[0])      stat_count <= 32'd0;
        else if (stat_cfg[1]) stat_count <= stat_count + 32'd1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] g, input logic l, input bit per);
        exp_t e;
        e.gain = g;
        e.lck  = l;
        e.per  = per;
        q.push_back(e);
    endtask

    // Monitor: a window result is presented when the DUT leaves UPDATE.
    always @(negedge mclk) begin
        exp_t e;
        if (mreset_n === 1'b1 && cfg_prev == 2'b00 && stat_cfg != 2'b00) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_update: gain=%h locked=%b with empty queue", pilot_gain, locked);
            end else begin
                e = q.pop_front();
                check("upd_gain", 32'(pilot_gain), 32'(e.gain));
                check("upd_locked", 32'(locked), 32'(e.lck));
                if (e.per) check("upd_period", cyc - last_done, 32'd105);
            end
            last_done <= cyc;
        end
        cfg_prev <= stat_cfg;
    end

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge mclk);
            n++;
        end
        check("drain_pending", 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic wait_cfg(input logic [1:0] v, input int budget);
        int n;
        n = 0;
        while (stat_cfg != v && n < budget) begin
            @(negedge mclk);
            n++;
        end
        check("wait_cfg", 32'(stat_cfg), 32'(v));
    endtask

    initial begin
        int n;
        int z;
        mreset_n = 1'b0; enable = 1'b0; to_enable = 1'b0;
        gain_load = 1'b0; gain_load_val = 16'h0000;
        target_pp = 9'd0; deadband = 8'd0; window = 32'd100;
        stat_min = 8'd0; stat_max = 8'd0;
        repeat (3) @(negedge mclk);

        // reset state
        check("rst_gain", 32'(pilot_gain), 32'h0100);
        check("rst_cfg", 32'(stat_cfg), 32'h1);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_timeout", 32'(timeout_err), 32'h0);
        check("rst_limit", stat_limit, 32'h0);
        mreset_n = 1'b1;

        // watchdog: IDLE->CLEAR, CLEAR->RUN, then 64 RUN cycles
        @(negedge mclk);
        to_enable = 1'b1;
        n = 0;
        while (to_err !== 1'b1 && n < 200) begin
            @(negedge mclk);
            n++;
        end
        check("to_cycles", 32'(n), 32'd66);
        check("to_cfg_clear", 32'(to_cfg), 32'h1);
        check("to_busy", 32'(to_busy), 32'h1);
        check("to_gain_held", 32'(to_gain), 32'h0100);
        @(negedge mclk);
        check("to_cfg_run", 32'(to_cfg), 32'h2);
        to_enable = 1'b0;
        @(negedge mclk);
        check("to_sticky", 32'(to_err), 32'h1);
        to_enable = 1'b1;
        @(negedge mclk);
        check("to_cleared", 32'(to_err), 32'h0);
        to_enable = 1'b0;

        // on target: gain held, locked after the 4th UPDATE, 105-cycle windows
        stat_min = 8'shC0; stat_max = 8'sh3F; target_pp = 9'd127; deadband = 8'd2;
        push(16'h0100, 1'b0, 1'b0);
        push(16'h0100, 1'b0, 1'b1);
        push(16'h0100, 1'b0, 1'b1);
        push(16'h0100, 1'b1, 1'b1);
        push(16'h0100, 1'b1, 1'b1);
        enable = 1'b1;
        wait_drain(700);

        // pp=200 above target 100: gain steps down
        stat_min = 8'sh9C; stat_max = 8'sh64; target_pp = 9'd100; deadband = 8'd4;
`ifdef PILOT_LVL_CTRL_PROP_STEP_EN
        push(16'h0000, 1'b0, 1'b1);
        push(16'h0000, 1'b0, 1'b1);
`else
        push(16'h00F0, 1'b0, 1'b1);
        push(16'h00E0, 1'b0, 1'b1);
`endif
        wait_drain(300);
        enable = 1'b0;
        @(negedge mclk);
        check("dis_busy", 32'(busy), 32'h0);
        check("dis_cfg", 32'(stat_cfg), 32'h1);
`ifdef PILOT_LVL_CTRL_PROP_STEP_EN
        check("dis_gain", 32'(pilot_gain), 32'h0000);
`else
        check("dis_gain", 32'(pilot_gain), 32'h00E0);
`endif
        gain_load = 1'b1; gain_load_val = 16'h0018;
        @(negedge mclk);
        gain_load = 1'b0;
        check("load_idle", 32'(pilot_gain), 32'h0018);
        // saturation at zero
`ifdef PILOT_LVL_CTRL_PROP_STEP_EN
        push(16'h0000, 1'b0, 1'b0);
`else
        push(16'h0008, 1'b0, 1'b0);
`endif
        push(16'h0000, 1'b0, 1'b1);
        push(16'h0000, 1'b0, 1'b1);
        enable = 1'b1;
        wait_drain(400);

        // deadband edges: err = +4 and -4 leave gain unchanged
        stat_min = 8'shC0; stat_max = 8'sh3F; target_pp = 9'd123;
        push(16'h0000, 1'b0, 1'b1);
        wait_drain(200);
        target_pp = 9'd131;
        push(16'h0000, 1'b0, 1'b1);
        wait_drain(200);

        // below target: gain steps up
        target_pp = 9'd200;
`ifdef PILOT_LVL_CTRL_PROP_STEP_EN
        push(16'h0100, 1'b0, 1'b1);
        push(16'h0200, 1'b0, 1'b1);
`else
        push(16'h0010, 1'b0, 1'b1);
        push(16'h0020, 1'b0, 1'b1);
`endif
        wait_drain(300);

        // saturation at full scale
        enable = 1'b0;
        @(negedge mclk);
        gain_load = 1'b1; gain_load_val = 16'hFFF8;
        @(negedge mclk);
        gain_load = 1'b0;
        push(16'hFFFF, 1'b0, 1'b0);
        push(16'hFFFF, 1'b0, 1'b1);
        enable = 1'b1;
        wait_drain(300);

        // gain_load in the UPDATE cycle wins over the step
        push(16'h0400, 1'b0, 1'b1);
        z = 0;
        n = 0;
        while (z < 3 && n < 300) begin
            @(negedge mclk);
            n++;
            z = (stat_cfg == 2'b00) ? z + 1 : 0;
        end
        check("update_found", 32'(z), 32'd3);
        gain_load = 1'b1; gain_load_val = 16'h0400;
        @(negedge mclk);
        gain_load = 1'b0;
        check("ld_upd_cfg", 32'(stat_cfg), 32'h1);
        check("ld_upd_busy", 32'(busy), 32'h1);
        wait_drain(5);

        // gain_load in mid-RUN abandons the window
        wait_cfg(2'b10, 20);
        repeat (10) @(negedge mclk);
        gain_load = 1'b1; gain_load_val = 16'h0300;
        @(negedge mclk);
        gain_load = 1'b0;
        check("ld_run_cfg", 32'(stat_cfg), 32'h1);
        check("ld_run_gain", 32'(pilot_gain), 32'h0300);
        check("ld_run_locked", 32'(locked), 32'h0);

        // enable dropped in RUN
        wait_cfg(2'b10, 20);
        repeat (5) @(negedge mclk);
        enable = 1'b0;
        @(negedge mclk);
        check("off_run_cfg", 32'(stat_cfg), 32'h1);
        check("off_run_busy", 32'(busy), 32'h0);
        check("off_run_gain", 32'(pilot_gain), 32'h0300);

        // large error: pp=255, target 55, deadband 0
        stat_min = 8'sh80; stat_max = 8'sh7F; target_pp = 9'd55; deadband = 8'd0;
        gain_load = 1'b1; gain_load_val = 16'h0400;
        @(negedge mclk);
        gain_load = 1'b0;
`ifdef PILOT_LVL_CTRL_PROP_STEP_EN
        push(16'h0300, 1'b0, 1'b0);
`else
        push(16'h03F0, 1'b0, 1'b0);
`endif
        enable = 1'b1;
        wait_drain(200);
        enable = 1'b0;
        repeat (3) @(negedge mclk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
